// File: rtl/y_mc_ctrl.sv
// Multi-cycle control unit for the lab MIPS subset: sequences FETCH/DECODE/EXEC/MEM/WB,
// drives ALU op and datapath strobes, and handshakes with a unified memory port.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_FETCH | instruction read from PC, wait for mem_ack (IR load + PC+4)
// ST_DECODE| classify opcode/funct into the class register
// ST_EXEC  | ALU operation; beq/j resolve the PC here and retire
// ST_MEM   | data access at ALU result, wait for mem_ack (sw retires)
// ST_WB    | register-file write (R, addi, lw) and retire
// ST_HALT  | fault latched, everything frozen until reset
module y_mc_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ack,
  output logic [2:0]       alu_op,
  output logic             alu_src_imm,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_data_sel,
  output logic             ir_write,
  output logic             pc_inc,
  output logic             pc_branch,
  output logic             pc_jump,
  output logic             reg_write,
  output logic             reg_dst_rd,
  output logic             mem_to_reg,
  output logic [1:0]       fault,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CL_R    = 3'd0,
    CL_LW   = 3'd1,
    CL_SW   = 3'd2,
    CL_BEQ  = 3'd3,
    CL_ADDI = 3'd4,
    CL_J    = 3'd5
  } cls_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] FLT_OK      = 2'b00;
  localparam logic [1:0] FLT_ILLEGAL = 2'b01;
  localparam logic [1:0] FLT_TIMEOUT = 2'b10;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t           state_q, state_d;
  cls_t             cls_q, cls_d;
  logic [2:0]       alu_q, alu_d;
  logic [7:0]       wait_q, wait_d;
  logic [1:0]       fault_q, fault_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  cls_t       dec_cls;
  logic [2:0] dec_alu;
  logic       dec_ok;
  logic       mem_wait;
  logic       timeout;
  logic       retire;

  // Decoder: the EXEC-cycle ALU op is resolved here so EXEC only looks at registers.
  always_comb begin
    dec_ok  = 1'b1;
    dec_cls = CL_R;
    dec_alu = ALU_ADD;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20:   dec_alu = ALU_ADD;
          6'h22:   dec_alu = ALU_SUB;
          6'h24:   dec_alu = ALU_AND;
          6'h25:   dec_alu = ALU_OR;
          6'h2A:   dec_alu = ALU_SLT;
          default: dec_ok  = 1'b0;
        endcase
      end
      6'h23:   dec_cls = CL_LW;
      6'h2B:   dec_cls = CL_SW;
      6'h04: begin
        dec_cls = CL_BEQ;
        dec_alu = ALU_SUB;
      end
      6'h08:   dec_cls = CL_ADDI;
      6'h02: begin
        dec_cls = CL_J;
        dec_alu = ALU_AND;
      end
      default: dec_ok = 1'b0;
    endcase
  end

  assign mem_wait = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign timeout  = mem_wait && !mem_ack && (wait_q == WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ack) begin
          state_d = ST_DECODE;
        end else if (timeout) begin
          state_d = ST_HALT;
        end
      end
      ST_DECODE: state_d = dec_ok ? ST_EXEC : ST_HALT;
      ST_EXEC: begin
        case (cls_q)
          CL_R, CL_ADDI: state_d = ST_WB;
          CL_LW, CL_SW:  state_d = ST_MEM;
          default:       state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (mem_ack) begin
          state_d = (cls_q == CL_SW) ? ST_FETCH : ST_WB;
        end else if (timeout) begin
          state_d = ST_HALT;
        end
      end
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    retire = 1'b0;
    case (state_q)
      ST_EXEC: retire = (cls_q == CL_BEQ) || (cls_q == CL_J);
      ST_MEM:  retire = mem_ack && (cls_q == CL_SW);
      ST_WB:   retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  always_comb begin
    cls_d     = cls_q;
    alu_d     = alu_q;
    fault_d   = fault_q;
    retired_d = retired_q;
    wait_d    = wait_q;

    if (state_q == ST_DECODE) begin
      cls_d = dec_cls;
      alu_d = dec_alu;
      if (!dec_ok) begin
        fault_d = FLT_ILLEGAL;
      end
    end

    if (timeout) begin
      fault_d = FLT_TIMEOUT;
    end

    if (retire) begin
      retired_d = retired_q + CNT_W'(1);
    end

    // Counter restarts on every entry into a memory-wait state; it never passes WAIT_LAST.
    if ((state_d != state_q) && ((state_d == ST_FETCH) || (state_d == ST_MEM))) begin
      wait_d = 8'd0;
    end else if (mem_wait && !mem_ack && !timeout) begin
      wait_d = wait_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls_q     <= CL_R;
      alu_q     <= ALU_AND;
      wait_q    <= 8'd0;
      fault_q   <= FLT_OK;
      retired_q <= '0;
    end else begin
      cls_q     <= cls_d;
      alu_q     <= alu_d;
      wait_q    <= wait_d;
      fault_q   <= fault_d;
      retired_q <= retired_d;
    end
  end

  // Strobes are forced low while reset is held, otherwise FETCH would raise mem_req during reset.
  always_comb begin
    alu_op       = ALU_AND;
    alu_src_imm  = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_data_sel = 1'b0;
    ir_write     = 1'b0;
    pc_inc       = 1'b0;
    pc_branch    = 1'b0;
    pc_jump      = 1'b0;
    reg_write    = 1'b0;
    reg_dst_rd   = 1'b0;
    mem_to_reg   = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_FETCH: begin
          mem_req  = 1'b1;
          ir_write = mem_ack;
          pc_inc   = mem_ack;
        end
        ST_EXEC: begin
          alu_op      = alu_q;
          alu_src_imm = (cls_q == CL_LW) || (cls_q == CL_SW) || (cls_q == CL_ADDI);
          pc_branch   = (cls_q == CL_BEQ) && zero;
          pc_jump     = (cls_q == CL_J);
        end
        ST_MEM: begin
          mem_req      = 1'b1;
          mem_data_sel = 1'b1;
          mem_we       = (cls_q == CL_SW);
        end
        ST_WB: begin
          reg_write  = 1'b1;
          reg_dst_rd = (cls_q == CL_R);
          mem_to_reg = (cls_q == CL_LW);
        end
        default: begin
          alu_op = ALU_AND;
        end
      endcase
    end
  end

  assign fault   = fault_q;
  assign retired = retired_q;

endmodule

// File: doc/y_mc_ctrl.md
Name: y_mc_ctrl

Overview:
- Multi-cycle control unit: the issuing end of the ALU op/zero interface.
- Sequences FETCH/DECODE/EXEC/MEM/WB for the MIPS subset.
- Drives the 3-bit ALU op and datapath strobes, consumes the ALU zero flag, and handshakes with a unified memory port.
- Sits between instruction register/PC logic and the ALU/register file of the lab CPU.

Parameters:
- TIMEOUT, 16, max cycles to wait for mem_ack in FETCH or MEM before fault (range 2..255).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instr[31:26], valid from DECODE onward (IR held stable)
- funct  in  6  instr[5:0]
- zero  in  1  ALU zero flag, sampled in EXEC
- mem_ack  in  1  memory completes the current request this cycle
- alu_op  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt
- alu_src_imm  out  1  ALU B = sign-extended immediate
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  write qualifier for mem_req (sw only)
- mem_data_sel  out  1  0 = instruction address (PC), 1 = data address (ALU result)
- ir_write  out  1  one-cycle IR load pulse
- pc_inc  out  1  one-cycle PC+4 pulse
- pc_branch  out  1  one-cycle PC+4+(imm<<2) pulse
- pc_jump  out  1  one-cycle jump-target load pulse
- reg_write  out  1  one-cycle register-file write pulse
- reg_dst_rd  out  1  destination rd (R-type) else rt
- mem_to_reg  out  1  write-back data from memory (lw)
- fault  out  2  sticky: 00 ok, 01 illegal instruction, 10 memory timeout
- retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = FETCH, wait counter = 0, fault = 00, retired = 0.
  - All strobes and alu_op = 0.
  - First cycle after release: mem_req = 1, mem_data_sel = 0.
- Outputs are Moore functions of state plus a class register latched in DECODE. No combinational path from opcode/funct to outputs outside DECODE.
- FETCH:
  - mem_req = 1, mem_we = 0.
  - Cycle with mem_ack = 1: ir_write = 1, pc_inc = 1, go to DECODE.
- DECODE (1 cycle):
  - Classify opcode: 0x00 R, 0x23 lw, 0x2B sw, 0x04 beq, 0x08 addi, 0x02 j.
  - R-type funct map: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt.
  - Unknown opcode or funct: fault = 01, go to HALT.
  - Otherwise go to EXEC.
- EXEC:
  - R: alu_op per funct, then WB.
  - addi: alu_op = 010, alu_src_imm = 1, then WB.
  - lw/sw: alu_op = 010, alu_src_imm = 1, then MEM.
  - beq: alu_op = 110; pc_branch = zero in this cycle; retired++; then FETCH.
  - j: pc_jump = 1, retired++, then FETCH.
- MEM:
  - mem_req = 1, mem_data_sel = 1, mem_we = 1 for sw.
  - On mem_ack: sw does retired++ and goes to FETCH; lw goes to WB.
- WB:
  - reg_write = 1, retired++, then FETCH.
  - reg_dst_rd = 1 for R; mem_to_reg = 1 for lw.
- Wait counter:
  - Clears on entry to FETCH/MEM; increments each cycle with mem_req = 1 and mem_ack = 0.
  - Counter reaching TIMEOUT without ack: fault = 10, go to HALT. Ack on the same cycle as TIMEOUT wins.
- HALT:
  - All strobes 0, fault and retired frozen.
  - Exit only via reset.
- mem_ack outside FETCH/MEM is ignored.
- retired wraps modulo 2^CNT_W.
- Reset mid-instruction: aborts immediately, with no trailing reg_write or pc pulse.

Test Plan:
- add (opcode 0x00, funct 0x20), mem_ack on the 1st FETCH cycle -> DECODE, EXEC with alu_op = 010, WB with reg_write = 1 and reg_dst_rd = 1; retired = 1 after 4 cycles.
- beq twice: zero = 1 then zero = 0 -> pc_branch pulses once, then is 0; each instruction takes 3 cycles; retired = 2.
- lw with mem_ack delayed 3 cycles in MEM -> mem_req, mem_data_sel = 1 held for 4 cycles; WB asserts mem_to_reg = 1 and reg_write = 1. sw -> mem_we = 1 and no reg_write.
- TIMEOUT = 4, mem_ack never asserted in FETCH -> fault = 10 after 4 wait cycles, mem_req drops, state stays in HALT for 20 cycles. Ack arriving exactly at count 4 -> no fault.
- opcode 0x3F, or R-type with funct 0x27 -> fault = 01 after DECODE; no reg_write, no pc pulse; retired unchanged.
- rst_n pulled low mid-MEM of sw, asynchronous to clk -> all outputs 0 immediately. After release: FETCH with mem_req = 1, retired = 0, fault = 00.
